cdc_xfer_arbiter: RTL and testbench

- Source-domain controller that shares one 4-phase CDC vector channel between N requesters.
- Round-robin arbitration; the winner's payload and its source ID go into a hold register that stays stable for the whole transfer.
- Sequences the req/ack handshake: the ack returns raw from the destination domain and is synchronized internally.
- Flags a stuck handshake with a timeout.

---
 rtl/cdc_xfer_pkg.sv | 13 +
 rtl/cdc_xfer_arbiter_rr_arbiter.sv | 32 +++
 rtl/cdc_xfer_arbiter.sv | 121 ++++++++++++
 tb/tb_cdc_xfer_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_xfer_pkg.sv
// Shared types for the CDC transfer arbiter: handshake FSM states and
// the depth of the ack synchronizer.
package cdc_xfer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACKLOW = 2'd2
  } xfer_state_t;

  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/cdc_xfer_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or above the
// pointer, wrapping modulo NUM_REQ.
module rr_arbiter
  import cdc_xfer_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  valid_i,
  input  logic [ID_WIDTH-1:0] ptr_i,
  output logic [NUM_REQ-1:0]  grant_oh_o,
  output logic [ID_WIDTH-1:0] grant_idx_o,
  output logic                any_valid_o
);

  always_comb begin
    logic [ID_WIDTH-1:0] idx;
    idx         = '0;
    grant_oh_o  = '0;
    grant_idx_o = '0;
    any_valid_o = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ID_WIDTH'((32'(ptr_i) + 32'(i)) % NUM_REQ);
      if (!any_valid_o && valid_i[idx]) begin
        any_valid_o      = 1'b1;
        grant_idx_o      = idx;
        grant_oh_o[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdc_xfer_arbiter.sv
// Source-domain controller sharing one 4-phase CDC vector channel between
// NUM_REQ requesters, with round-robin arbitration and a handshake timeout.
module cdc_xfer_arbiter
  import cdc_xfer_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int ID_WIDTH       = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           xfer_req,
  output logic [ID_WIDTH+DATA_WIDTH-1:0] xfer_data,
  input  logic                           xfer_ack,
  output logic                           busy,
  output logic                           timeout_err,
  input  logic                           err_clear
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  xfer_state_t                    state_q;
  logic [ID_WIDTH-1:0]            ptr_q, ptr_d;
  logic [CNT_W-1:0]               cnt_q;
  logic                           xfer_req_q, timeout_err_q;
  logic [ID_WIDTH+DATA_WIDTH-1:0] xfer_data_q;
  logic [SYNC_DEPTH-1:0]          ack_sync_q;
  logic                           ack_s;

  logic [NUM_REQ-1:0]    grant_oh;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic                  any_valid;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic                  tick_en, cnt_hit;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr (
    .valid_i     (req_valid),
    .ptr_i       (ptr_q),
    .grant_oh_o  (grant_oh),
    .grant_idx_o (grant_idx),
    .any_valid_o (any_valid)
  );

  // Raw ack is never used combinationally; only ack_s feeds the FSM.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ack_sync_q <= '0;
    else         ack_sync_q <= {ack_sync_q[SYNC_DEPTH-2:0], xfer_ack};
  end
  assign ack_s = ack_sync_q[SYNC_DEPTH-1];

  assign ptr_d   = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + ID_WIDTH'(1);
  assign tick_en = (TIMEOUT_CYCLES != 0) && !timeout_err_q;
  assign cnt_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Once the timeout fires the FSM freezes until err_clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      cnt_q         <= '0;
      xfer_req_q    <= 1'b0;
      xfer_data_q   <= '0;
      timeout_err_q <= 1'b0;
    end else if (err_clear) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      xfer_req_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_valid) begin
            xfer_data_q <= {grant_idx, data_arr[grant_idx]};
            ptr_q       <= ptr_d;
            xfer_req_q  <= 1'b1;
            cnt_q       <= '0;
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (ack_s && !timeout_err_q) begin
            xfer_req_q <= 1'b0;
            cnt_q      <= '0;
            state_q    <= ACKLOW;
          end else if (tick_en) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_hit) timeout_err_q <= 1'b1;
          end
        end
        ACKLOW: begin
          if (!ack_s && !timeout_err_q) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (tick_en) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_hit) timeout_err_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = (state_q == IDLE && !err_clear) ? grant_oh : '0;
  assign xfer_req    = xfer_req_q;
  assign xfer_data   = xfer_data_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// Directed bench for cdc_xfer_arbiter: reset, round-robin order, single
// transfer timing, data hold, timeout/err_clear, ack glitch, async reset.
module tb_cdc_xfer_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        xfer_req;
  logic [17:0] xfer_data;
  logic        xfer_ack;
  logic        busy;
  logic        timeout_err;
  logic        err_clear;

  int errors = 0;
  int checks = 0;

  cdc_xfer_arbiter #(
    .NUM_REQ        (4),
    .DATA_WIDTH     (16),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .xfer_req    (xfer_req),
    .xfer_data   (xfer_data),
    .xfer_ack    (xfer_ack),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_clear   (err_clear)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig_of(input int which);
    case (which)
      0:       return xfer_req;
      1:       return busy;
      default: return timeout_err;
    endcase
  endfunction

  task automatic wait_lvl(input int which, input logic lvl, input int max_cyc, output int n);
    n = 0;
    while (sig_of(which) !== lvl && n < max_cyc) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; req_valid = '0; req_data = '0; xfer_ack = 1'b0; err_clear = 1'b0;
    tick(); tick(); tick();
    checks++; if (xfer_req !== 1'b0) begin errors++; $display("FAIL rst_xfer_req got %b want 0", xfer_req); end
    checks++; if (xfer_data !== 18'h0) begin errors++; $display("FAIL rst_xfer_data got %h want 0", xfer_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout_err got %b want 0", timeout_err); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready got %b want 0000", req_ready); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    int n;
    logic [1:0]  exp_id;
    logic [17:0] exp;
    req_data  = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_id = 2'(k % 4);
      exp    = {exp_id, 14'h2800, exp_id};
      wait_lvl(0, 1'b1, 10, n);
      checks++; if (xfer_req !== 1'b1) begin errors++; $display("FAIL rr_req_rise[%0d] got %b want 1", k, xfer_req); end
      checks++; if (xfer_data !== exp) begin errors++; $display("FAIL rr_grant[%0d] got %h want %h", k, xfer_data, exp); end
      xfer_ack = 1'b1;
      wait_lvl(0, 1'b0, 10, n);
      checks++; if (xfer_req !== 1'b0) begin errors++; $display("FAIL rr_req_fall[%0d] got %b want 0", k, xfer_req); end
      if (k == 4) req_valid = 4'b0000;
      xfer_ack = 1'b0;
      wait_lvl(1, 1'b0, 10, n);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_busy_fall[%0d] got %b want 0", k, busy); end
    end
  endtask

  task automatic test_single();
    int n;
    req_data  = 64'h0000_BEEF_0000_0000;
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b want 0100", req_ready); end
    tick();
    req_valid = 4'b0000;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_req got %b want 0000", req_ready); end
    checks++; if (xfer_req !== 1'b1) begin errors++; $display("FAIL single_req got %b want 1", xfer_req); end
    checks++; if (xfer_data !== {2'd2, 16'hBEEF}) begin errors++; $display("FAIL single_data got %h want %h", xfer_data, {2'd2, 16'hBEEF}); end
    tick();
    xfer_ack = 1'b1;
    wait_lvl(0, 1'b0, 10, n);
    checks++; if (n < 2 || n > 3) begin errors++; $display("FAIL single_req_fall_lat got %0d want 2..3", n); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_acklow got %b want 1", busy); end
    xfer_ack = 1'b0;
    wait_lvl(1, 1'b0, 10, n);
    checks++; if (n < 2 || n > 3) begin errors++; $display("FAIL single_busy_fall_lat got %0d want 2..3", n); end
  endtask

  task automatic test_data_hold();
    int n;
    req_data  = 64'h0000_0000_0000_1111;
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    checks++; if (xfer_data !== {2'd0, 16'h1111}) begin errors++; $display("FAIL hold_capture got %h want %h", xfer_data, {2'd0, 16'h1111}); end
    req_data = 64'h0000_0000_0000_2222;
    tick();
    checks++; if (xfer_data !== {2'd0, 16'h1111}) begin errors++; $display("FAIL hold_req got %h want %h", xfer_data, {2'd0, 16'h1111}); end
    xfer_ack = 1'b1;
    wait_lvl(0, 1'b0, 10, n);
    checks++; if (xfer_data !== {2'd0, 16'h1111}) begin errors++; $display("FAIL hold_acklow got %h want %h", xfer_data, {2'd0, 16'h1111}); end
    xfer_ack = 1'b0;
    wait_lvl(1, 1'b0, 10, n);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_busy_fall got %b want 0", busy); end
    checks++; if (xfer_data !== {2'd0, 16'h1111}) begin errors++; $display("FAIL hold_idle got %h want %h", xfer_data, {2'd0, 16'h1111}); end
  endtask

  task automatic test_timeout();
    req_data  = 64'h0000_0000_5A5A_0000;
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0000;
    for (int c = 1; c < 8; c++) begin
      tick();
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_early[%0d] got %b want 0", c, timeout_err); end
    end
    tick();
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_set got %b want 1", timeout_err); end
    checks++; if (xfer_req !== 1'b1) begin errors++; $display("FAIL to_req_held got %b want 1", xfer_req); end
    tick(); tick();
    checks++; if (timeout_err !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL to_sticky got err=%b busy=%b want 1 1", timeout_err, busy); end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear_err got %b want 0", timeout_err); end
    checks++; if (xfer_req !== 1'b0) begin errors++; $display("FAIL to_clear_req got %b want 0", xfer_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_clear_busy got %b want 0", busy); end
  endtask

  task automatic test_ack_glitch();
    int n;
    req_data  = 64'h0000_C0DE_0000_0000;
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0000;
    #1 xfer_ack = 1'b1;
    #4 xfer_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (xfer_req !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL glitch_hold[%0d] got req=%b busy=%b want 1 1", c, xfer_req, busy); end
    end
    xfer_ack = 1'b1;
    wait_lvl(0, 1'b0, 10, n);
    xfer_ack = 1'b0;
    wait_lvl(1, 1'b0, 10, n);
    checks++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL glitch_finish got busy=%b err=%b want 0 0", busy, timeout_err); end
  endtask

  task automatic test_async_reset();
    int n;
    req_data  = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0000;
    checks++; if (xfer_data !== {2'd1, 16'hD001}) begin errors++; $display("FAIL ar_pre_grant got %h want %h", xfer_data, {2'd1, 16'hD001}); end
    xfer_ack = 1'b1;
    wait_lvl(0, 1'b0, 10, n);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ar_in_acklow got %b want 1", busy); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (xfer_req !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL ar_ctrl got req=%b busy=%b err=%b want 0 0 0", xfer_req, busy, timeout_err); end
    checks++; if (xfer_data !== 18'h0) begin errors++; $display("FAIL ar_data got %h want 0", xfer_data); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL ar_ready got %b want 0000", req_ready); end
    xfer_ack = 1'b0;
    tick(); tick();
    resetn    = 1'b1;
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL ar_first_ready got %b want 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    checks++; if (xfer_data !== {2'd0, 16'hD000} || xfer_req !== 1'b1) begin errors++; $display("FAIL ar_first_grant got %h req=%b want %h 1", xfer_data, xfer_req, {2'd0, 16'hD000}); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_data_hold();
    test_timeout();
    test_ack_glitch();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
